uart_alu_parser: RTL and testbench

Packet parser that sits directly downstream of the UART receiver inside `uart_alu`. It consumes received bytes (8N1, 115200 baud, 33 ns clock) and decodes the host packet header. Echo payload bytes are forwarded to the echo path. Arithmetic payloads are assembled into little-endian 32-bit operands for the ALU datapath. Malformed packets, output overruns and stalled transfers are flagged on a one-cycle error pulse.

---
 rtl/uart_alu_parser.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_alu_parser.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_parser.sv
// uart_alu_parser: decodes host packets from the UART receiver into echo bytes
// and little-endian 32-bit ALU operands, flagging malformed or stalled traffic.
module uart_alu_parser #(
  parameter int unsigned TimeoutCycles = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        echo_valid_o,
  output logic [7:0]  echo_data_o,
  input  logic        echo_ready_i,
  output logic        op_valid_o,
  output logic [7:0]  op_code_o,
  output logic [31:0] op_data_o,
  output logic        op_first_o,
  output logic        op_last_o,
  input  logic        op_ready_i,
  output logic        error_o,
  output logic [1:0]  error_code_o,
  output logic        busy_o
);

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'h88;
  localparam logic [7:0] OP_DIV  = 8'hD0;

  localparam logic [1:0] ERR_OPCODE  = 2'd0;
  localparam logic [1:0] ERR_LENGTH  = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_SKIP
  } state_t;

  state_t      state, state_next;
  logic        discard;
  logic [7:0]  len_lo;
  logic [15:0] remain;
  logic [31:0] shift_word;
  logic [1:0]  byte_cnt;
  logic        first_pending;
  logic [31:0] tcount;

  logic [15:0] length;
  logic [15:0] remain_dec;
  logic        known;
  logic        is_echo;
  logic        timeout_hit;
  logic [31:0] word;

  logic        err_set;
  logic [1:0]  err_code;
  logic        echo_load;
  logic        op_load;

  assign length      = {rx_data_i, len_lo};
  assign remain_dec  = remain - 16'd1;
  assign known       = (rx_data_i == OP_ECHO) || (rx_data_i == OP_ADD) ||
                       (rx_data_i == OP_MUL)  || (rx_data_i == OP_DIV);
  assign is_echo     = (op_code_o == OP_ECHO);
  assign timeout_hit = !rx_valid_i && (state != S_IDLE) &&
                       (tcount == TimeoutCycles - 1);
  assign word        = {rx_data_i, shift_word[31:8]};

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode; advances only on an accepted byte, or aborts on timeout.
  // A zero-length remainder never enters SKIP, otherwise it would swallow the
  // next packet's opcode byte.
  always_comb begin
    state_next = state;
    if (rx_valid_i) begin
      case (state)
        S_IDLE:   state_next = S_RSVD;
        S_RSVD:   state_next = S_LEN_LO;
        S_LEN_LO: state_next = S_LEN_HI;
        S_LEN_HI: begin
          if (discard)                     state_next = (length <= 16'd4) ? S_IDLE : S_SKIP;
          else if (length < 16'd4)         state_next = S_IDLE;
          else if (length == 16'd4)        state_next = S_IDLE;
          else if (is_echo)                state_next = S_PAYLOAD;
          else if (length[1:0] != 2'b00 || length < 16'd12)
                                           state_next = S_SKIP;
          else                             state_next = S_PAYLOAD;
        end
        S_PAYLOAD, S_SKIP: if (remain_dec == 16'd0) state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next = S_IDLE;
    end
  end

  // Per-cycle decisions: error reporting and output-register loads.
  always_comb begin
    err_set   = 1'b0;
    err_code  = ERR_OPCODE;
    echo_load = 1'b0;
    op_load   = 1'b0;
    if (rx_valid_i) begin
      case (state)
        S_IDLE: if (!known) begin
          err_set  = 1'b1;
          err_code = ERR_OPCODE;
        end
        S_LEN_HI: if (!discard) begin
          if (length < 16'd4 ||
              (!is_echo && (length[1:0] != 2'b00 || length < 16'd12))) begin
            err_set  = 1'b1;
            err_code = ERR_LENGTH;
          end
        end
        S_PAYLOAD: begin
          if (is_echo) begin
            if (echo_valid_o && !echo_ready_i) begin
              err_set  = 1'b1;
              err_code = ERR_OVERRUN;
            end else begin
              echo_load = 1'b1;
            end
          end else if (byte_cnt == 2'd3) begin
            if (op_valid_o && !op_ready_i) begin
              err_set  = 1'b1;
              err_code = ERR_OVERRUN;
            end else begin
              op_load = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end else if (timeout_hit) begin
      err_set  = 1'b1;
      err_code = ERR_TIMEOUT;
    end
  end

  // Header capture, payload counters, operand assembly and idle timer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_code_o     <= '0;
      discard       <= 1'b0;
      len_lo        <= '0;
      remain        <= '0;
      shift_word    <= '0;
      byte_cnt      <= '0;
      first_pending <= 1'b0;
      tcount        <= '0;
    end else begin
      if (rx_valid_i) begin
        case (state)
          S_IDLE: begin
            discard <= !known;
            if (known) op_code_o <= rx_data_i;
          end
          S_LEN_LO: len_lo <= rx_data_i;
          S_LEN_HI: begin
            remain        <= length - 16'd4;
            shift_word    <= '0;
            byte_cnt      <= '0;
            first_pending <= 1'b1;
          end
          S_PAYLOAD: begin
            remain <= remain_dec;
            if (!is_echo) begin
              shift_word <= word;
              byte_cnt   <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) first_pending <= 1'b0;
            end
          end
          S_SKIP:  remain <= remain_dec;
          default: ;
        endcase
      end else if (timeout_hit) begin
        shift_word <= '0;
        byte_cnt   <= '0;
      end
      if (rx_valid_i || state == S_IDLE || timeout_hit) tcount <= '0;
      else                                              tcount <= tcount + 32'd1;
    end
  end

  // Output registers with valid/ready hold; a load wins over a same-cycle accept.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      echo_valid_o <= 1'b0;
      echo_data_o  <= '0;
      op_valid_o   <= 1'b0;
      op_data_o    <= '0;
      op_first_o   <= 1'b0;
      op_last_o    <= 1'b0;
      error_o      <= 1'b0;
      error_code_o <= '0;
      busy_o       <= 1'b0;
    end else begin
      if (echo_load) begin
        echo_valid_o <= 1'b1;
        echo_data_o  <= rx_data_i;
      end else if (echo_ready_i) begin
        echo_valid_o <= 1'b0;
      end
      if (op_load) begin
        op_valid_o <= 1'b1;
        op_data_o  <= word;
        op_first_o <= first_pending;
        op_last_o  <= (remain_dec == 16'd0);
      end else if (op_ready_i) begin
        op_valid_o <= 1'b0;
      end
      error_o <= err_set;
      if (err_set) error_code_o <= err_code;
      busy_o <= (state_next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_alu_parser.sv
// Self-checking bench for uart_alu_parser: a table of per-byte vectors for
// the main packet flows plus hand-written overrun, timeout and reset sequences.
module tb_uart_alu_parser;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        echo_valid_o;
  logic [7:0]  echo_data_o;
  logic        echo_ready_i = 1'b1;
  logic        op_valid_o;
  logic [7:0]  op_code_o;
  logic [31:0] op_data_o;
  logic        op_first_o;
  logic        op_last_o;
  logic        op_ready_i = 1'b1;
  logic        error_o;
  logic [1:0]  error_code_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  uart_alu_parser #(.TimeoutCycles(50000)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .echo_valid_o(echo_valid_o), .echo_data_o(echo_data_o), .echo_ready_i(echo_ready_i),
    .op_valid_o(op_valid_o), .op_code_o(op_code_o), .op_data_o(op_data_o),
    .op_first_o(op_first_o), .op_last_o(op_last_o), .op_ready_i(op_ready_i),
    .error_o(error_o), .error_code_o(error_code_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        ev;
    logic [7:0]  ed;
    logic        ov;
    logic [31:0] od;
    logic        of;
    logic        ol;
    logic        e;
    logic [1:0]  ec;
    logic        b;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic ev, logic [7:0] ed,
                              logic ov, logic [31:0] od, logic of, logic ol,
                              logic e, logic [1:0] ec, logic b);
    vec_t r;
    r.v = v; r.d = d; r.ev = ev; r.ed = ed; r.ov = ov; r.od = od;
    r.of = of; r.ol = ol; r.e = e; r.ec = ec; r.b = b;
    return r;
  endfunction

  function automatic logic [47:0] outs();
    return {echo_valid_o, echo_data_o, op_valid_o, op_data_o,
            op_first_o, op_last_o, error_o, error_code_o, busy_o};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One-cycle byte strobe; outputs are sampled 1 time unit after the edge.
  task automatic send(input logic v, input logic [7:0] d);
    @(negedge clk_i);
    rx_valid_i = v;
    rx_data_i  = d;
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(1'b1, bytes[i]);
  endtask

  initial begin
    logic [47:0] expv;
    logic [7:0]  pkt[$];
    int          n;

    // Echo EC 00 06 00 41 42
    vecs.push_back(mk(1,8'hEC, 0,8'h00, 0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,8'h00, 0,8'h00, 0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,8'h06, 0,8'h00, 0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,8'h00, 0,8'h00, 0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,8'h41, 1,8'h41, 0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,8'h42, 1,8'h42, 0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,8'h00, 0,8'h42, 0,0,0,0, 0,0,0));
    // Add AD 00 0C 00 01000000 02000000
    vecs.push_back(mk(1,8'hAD, 0,8'h42, 0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,8'h0C, 0,8'h42, 0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,8'h01, 0,8'h42, 0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 1,1,1,0, 0,0,1));
    vecs.push_back(mk(1,8'h02, 0,8'h42, 0,1,1,0, 0,0,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,1,1,0, 0,0,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,1,1,0, 0,0,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 1,2,0,1, 0,0,0));
    vecs.push_back(mk(0,8'h00, 0,8'h42, 0,2,0,1, 0,0,0));
    // Bad opcode 55 00 05 00 FF
    vecs.push_back(mk(1,8'h55, 0,8'h42, 0,2,0,1, 1,0,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,2,0,1, 0,0,1));
    vecs.push_back(mk(1,8'h05, 0,8'h42, 0,2,0,1, 0,0,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,2,0,1, 0,0,1));
    vecs.push_back(mk(1,8'hFF, 0,8'h42, 0,2,0,1, 0,0,0));
    // Length below header size: EC 00 03 00
    vecs.push_back(mk(1,8'hEC, 0,8'h42, 0,2,0,1, 0,0,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,2,0,1, 0,0,1));
    vecs.push_back(mk(1,8'h03, 0,8'h42, 0,2,0,1, 0,0,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,2,0,1, 1,1,0));
    // Empty echo: EC 00 04 00
    vecs.push_back(mk(1,8'hEC, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h04, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,2,0,1, 0,1,0));
    // Bad length: 88 00 0A 00 + 6 skipped bytes
    vecs.push_back(mk(1,8'h88, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h0A, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,2,0,1, 1,1,1));
    vecs.push_back(mk(1,8'h11, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h12, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h13, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h14, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h15, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h16, 0,8'h42, 0,2,0,1, 0,1,0));
    // Add AD 00 0C 00 05000000 07000000
    vecs.push_back(mk(1,8'hAD, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h0C, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h05, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,2,0,1, 0,1,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 1,5,1,0, 0,1,1));
    vecs.push_back(mk(1,8'h07, 0,8'h42, 0,5,1,0, 0,1,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,5,1,0, 0,1,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 0,5,1,0, 0,1,1));
    vecs.push_back(mk(1,8'h00, 0,8'h42, 1,7,0,1, 0,1,0));
    vecs.push_back(mk(0,8'h00, 0,8'h42, 0,7,0,1, 0,1,0));

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_outputs", {outs(), op_code_o}, 64'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Table-driven flows
    foreach (vecs[i]) begin
      send(vecs[i].v, vecs[i].d);
      expv = {vecs[i].ev, vecs[i].ed, vecs[i].ov, vecs[i].od,
              vecs[i].of, vecs[i].ol, vecs[i].e, vecs[i].ec, vecs[i].b};
      chk($sformatf("vec%0d", i), outs(), expv);
      if (i == 19) chk("opcode_add", op_code_o, 8'hAD);
    end
    chk("opcode_after_table", op_code_o, 8'hAD);

    // Echo overrun: consumer stalled, second byte dropped
    echo_ready_i = 1'b0;
    pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41};
    send_pkt(pkt);
    chk("ovr_echo_held", {echo_valid_o, echo_data_o}, {1'b1, 8'h41});
    send(1'b1, 8'h42);
    chk("ovr_echo_err", {error_o, error_code_o, echo_valid_o, echo_data_o, busy_o},
        {1'b1, 2'd2, 1'b1, 8'h41, 1'b0});
    @(negedge clk_i);
    echo_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("ovr_echo_drain", {error_o, echo_valid_o, echo_data_o}, {1'b0, 1'b0, 8'h41});

    // Operand overrun: second word dropped, first word held intact
    op_ready_i = 1'b0;
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt);
    chk("ovr_op_held", {op_valid_o, op_data_o, op_first_o, op_last_o, error_o},
        {1'b1, 32'h1, 1'b1, 1'b0, 1'b0});
    pkt = '{8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt);
    chk("ovr_op_err", {error_o, error_code_o, op_valid_o, op_data_o, op_first_o, op_last_o, busy_o},
        {1'b1, 2'd2, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0});
    @(negedge clk_i);
    op_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("ovr_op_drain", {op_valid_o, op_data_o}, {1'b0, 32'h1});

    // Timeout: AD 00 then silence; error expected exactly 50000 cycles later
    pkt = '{8'hAD, 8'h00};
    send_pkt(pkt);
    n = 0;
    for (int c = 1; c <= 50100; c++) begin
      @(posedge clk_i);
      #1;
      if (error_o) begin
        n = c;
        break;
      end
    end
    chk("timeout_cycles", n, 50000);
    chk("timeout_state", {error_code_o, busy_o}, {2'd3, 1'b0});

    // Reset mid-payload clears everything immediately
    echo_ready_i = 1'b0;
    pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h41};
    send_pkt(pkt);
    chk("pre_reset_busy", {echo_valid_o, echo_data_o, busy_o}, {1'b1, 8'h41, 1'b1});
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_reset", {outs(), op_code_o}, 64'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    echo_ready_i = 1'b1;
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    send_pkt(pkt);
    chk("post_reset_echo", {echo_valid_o, echo_data_o, error_o, error_code_o, busy_o, op_code_o},
        {1'b1, 8'h5A, 1'b0, 2'd0, 1'b0, 8'hEC});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
